// File: rtl/dec_scoreboard_pkg.sv
// Shared CPU package for the decode scoreboard: default register-address
// width, register-count derivation and the register-index type.
package dec_scoreboard_pkg;

    localparam int DEF_ADDR_W = 3;

    // Register index as seen by decode and writeback.
    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

    // Number of architectural registers for a given index width.
    function automatic int reg_count(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/dec_scoreboard_onehot_dec.sv
// onehot_dec: combinational ADDR_W-to-N one-hot decoder with enable.
// Ports: en (enable), addr (index), onehot (N-bit decode, zero when !en).
module onehot_dec
    import dec_scoreboard_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                          en,
    input  logic [ADDR_W-1:0]             addr,
    output logic [reg_count(ADDR_W)-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_scoreboard.sv
// dec_scoreboard: per-register pending-write scoreboard for decode.
// Ports: clk, reset (sync, active high); issue_en/issue_addr request a
// destination; wb_en/wb_addr retire one; stall, flush pipeline controls;
// issue_onehot, wb_onehot, busy, busy_count registered; hazard combinational.
module dec_scoreboard
    import dec_scoreboard_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue_en,
    input  logic [ADDR_W-1:0]             issue_addr,
    input  logic                          wb_en,
    input  logic [ADDR_W-1:0]             wb_addr,
    input  logic                          stall,
    input  logic                          flush,
    output logic [reg_count(ADDR_W)-1:0]  issue_onehot,
    output logic [reg_count(ADDR_W)-1:0]  wb_onehot,
    output logic [reg_count(ADDR_W)-1:0]  busy,
    output logic [ADDR_W:0]               busy_count,
    output logic                          hazard
);

    localparam int N = reg_count(ADDR_W);

    logic [N-1:0]  issue_dec;
    logic [N-1:0]  wb_dec;
    logic [N-1:0]  set_mask;
    logic [N-1:0]  busy_next;
    logic [N-1:0]  issue_next;
    logic [ADDR_W:0] count_next;
    logic          accept;
    logic          wb_match;
    logic          zero_idx;

    assign zero_idx = (ZERO_REG == 1'b1) && (issue_addr == '0);
    assign wb_match = wb_en && (wb_addr == issue_addr);

    // A writeback to the same register this cycle resolves the hazard.
    assign hazard = issue_en && busy[issue_addr] && !wb_match && !zero_idx;
    assign accept = issue_en && !stall && !hazard && !flush;

    onehot_dec #(.ADDR_W(ADDR_W)) u_issue_dec (
        .en     (accept),
        .addr   (issue_addr),
        .onehot (issue_dec)
    );

    onehot_dec #(.ADDR_W(ADDR_W)) u_wb_dec (
        .en     (wb_en),
        .addr   (wb_addr),
        .onehot (wb_dec)
    );

    always_comb begin
        set_mask = issue_dec;
        if (ZERO_REG) begin
            set_mask[0] = 1'b0;
        end

        // Set is applied after clear so a new writer supersedes the old one.
        if (flush) begin
            busy_next = '0;
        end else begin
            busy_next = (busy & ~wb_dec) | set_mask;
        end

        if (flush) begin
            issue_next = '0;
        end else if (accept) begin
            issue_next = issue_dec;
        end else if (stall) begin
            issue_next = issue_onehot;
        end else begin
            issue_next = '0;
        end

        // Count the next-state vector so the registered count lines up
        // with the registered busy bits.
        count_next = '0;
        for (int i = 0; i < N; i++) begin
            count_next = count_next + (ADDR_W+1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_onehot <= '0;
            wb_onehot    <= '0;
            busy         <= '0;
            busy_count   <= '0;
        end else begin
            issue_onehot <= issue_next;
            wb_onehot    <= wb_dec;
            busy         <= busy_next;
            busy_count   <= count_next;
        end
    end

endmodule

// File: doc/dec_scoreboard.md
DEC_SCOREBOARD -- requirements
Module: dec_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 3, register-address width; N = 2**ADDR_W is derived, not overridable.
REQ-002 Parameter ZERO_REG, default 1; when 1, index 0 is never marked busy and never raises a hazard.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 issue_en  input  1  an instruction in decode requests a destination register.
REQ-006 issue_addr  input  ADDR_W  destination register index.
REQ-007 wb_en  input  1  writeback stage writes a register this cycle.
REQ-008 wb_addr  input  ADDR_W  writeback register index.
REQ-009 stall  input  1  pipeline stall; blocks issue acceptance.
REQ-010 flush  input  1  pipeline flush; kills all in-flight destinations.
REQ-011 issue_onehot  output  N  registered one-hot decode of the last accepted issue_addr.
REQ-012 wb_onehot  output  N  registered one-hot decode of wb_addr (register-file write enables).
REQ-013 busy  output  N  per-register pending-write bit.
REQ-014 busy_count  output  ADDR_W+1  registered population count of busy.
REQ-015 hazard  output  1  combinational; issue_en asserted while the target register is busy and not being written back this cycle.

Function
REQ-016 hazard = issue_en & busy[issue_addr] & ~(wb_en & wb_addr==issue_addr); it is forced to 0 when ZERO_REG=1 and issue_addr=0.
REQ-017 Accept = issue_en & ~stall & ~hazard & ~flush.
REQ-018 On accept: busy[issue_addr] is set next cycle and issue_onehot equals 1<<issue_addr next cycle. With ZERO_REG=1 and issue_addr=0, issue_onehot still decodes but busy[0] stays 0.
REQ-019 Without accept: issue_onehot is all-zero next cycle, except during stall without flush, when issue_onehot holds its value.
REQ-020 When wb_en=1, wb_onehot equals 1<<wb_addr next cycle; otherwise it is 0. wb_onehot is unaffected by stall.
REQ-021 When wb_en=1 and flush=0, busy[wb_addr] clears next cycle.
REQ-022 Same index set (accept) and cleared (wb) in one cycle: set wins, bit ends at 1 because the new writer supersedes the old one.
REQ-023 Different indices set and cleared in one cycle: both take effect.
REQ-024 wb_en to a non-busy register is legal: no error, and busy stays 0.
REQ-025 flush=1: all busy bits and issue_onehot are 0 next cycle, taking priority over issue and stall; wb_onehot still reflects wb_en/wb_addr.
REQ-026 busy_count tracks the next-state busy vector, so it is always equal to popcount(busy) in the same cycle; maximum value is N, or N-1 when ZERO_REG=1.
REQ-027 Latency: one cycle from input to issue_onehot, wb_onehot, busy and busy_count; zero cycles for hazard.

Reset
REQ-028 While reset=1 at a clock edge: issue_onehot, wb_onehot, busy and busy_count are all 0 next cycle; reset overrides flush, issue and wb.
REQ-029 Reset asserted mid-operation discards all pending busy bits; no state survives the reset.

Structure
REQ-030 The shared CPU package holds the ADDR_W default, the N derivation function, and the reg-index typedef used by decode and writeback.
REQ-031 One sub-module, onehot_dec (parametrised ADDR_W-to-N with enable, purely combinational), is instantiated twice: once for issue and once for writeback.
REQ-032 The busy vector and count live in dec_scoreboard; there is no other hierarchy.

Verification
REQ-033 Reset, then issue_en=1, issue_addr=5 -> next cycle issue_onehot=0x20, busy=0x20, busy_count=1, hazard=0.
REQ-034 busy=0x20, then issue_addr=5 with no wb -> hazard=1, no accept, issue_onehot=0 next cycle; same cycle with wb_en=1, wb_addr=5 -> hazard=0 and busy stays 0x20 (REQ-022).
REQ-035 busy=0x0C, wb_addr=2 and issue_addr=6 in the same cycle -> busy=0x48, wb_onehot=0x04, busy_count=2.
REQ-036 stall=1 with issue_addr=3 after issue_onehot=0x02 -> issue_onehot holds 0x02 and busy is unchanged; stall+flush -> all busy and issue_onehot 0.
REQ-037 ZERO_REG=1, issue_addr=0 -> issue_onehot=0x01, busy[0]=0, hazard never asserted; ADDR_W=5 build: fill all 31 nonzero registers -> busy_count=31.
REQ-038 Reset asserted with busy=0xFF and wb_en=1 -> all outputs 0 next cycle.
